control_fsm: RTL and testbench

Multi-cycle control unit that sits directly downstream of the PC/SP/memory block's instruction register. It consumes the latched 16-bit instruction and sequences FETCH/DECODE/MEM cycles. It drives every write enable and mux select of the PC, SP, memory and instruction-register datapath, and counts retired instructions.

---
 rtl/control_fsm.sv | 214 +++++++++++++++++++++
 tb/tb_control_fsm.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle FETCH/DECODE/MEM sequencer for the PC/SP/memory datapath.
// Consumes the latched instruction register, drives every write enable and mux select of
// the datapath, and counts retired instructions.
//
// Optional feature macro: HALT_EN
//   defined   -> opcode 0x9 retires and parks the FSM in HALTED until reset
//   undefined -> opcode 0x9 is illegal (NOP behaviour), halted is tied low
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset; also forces all outputs low while asserted
//   i_run          sampled only in FETCH; low stalls in FETCH with no writes
//   i_inst[15:0]   instruction register output, opcode = i_inst[15:12]
//   i_cmp_true     BEQ comparator result, sampled in DECODE
//   o_pc_write, o_sp_write, o_mem_write, o_inst_write, o_mary_write, o_ra_write  write enables
//   o_pc_src[2:0]  0=PC+2, 1=immAddr, 2=ra, 4=comp
//   o_sp_src[1:0]  1=sp-2, 2=sp+2
//   o_mem_src[1:0] memory address: 0=pc, 1=sp, 2=ze_imm
//   o_mem_dst[2:0] memory write data: 0=Mary
//   o_retired      pulse in an instruction's final cycle
//   o_illegal      pulse in DECODE for an undefined opcode
//   o_halted       high while in HALTED
//   o_state[1:0]   0=FETCH, 1=DECODE, 2=MEM, 3=HALTED
//   o_inst_count   retired-instruction count, wraps silently
module control_fsm #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_run,
  input  logic [15:0]        i_inst,
  input  logic               i_cmp_true,
  output logic               o_pc_write,
  output logic               o_sp_write,
  output logic               o_mem_write,
  output logic               o_inst_write,
  output logic               o_mary_write,
  output logic               o_ra_write,
  output logic [2:0]         o_pc_src,
  output logic [1:0]         o_sp_src,
  output logic [1:0]         o_mem_src,
  output logic [2:0]         o_mem_dst,
  output logic               o_retired,
  output logic               o_illegal,
  output logic               o_halted,
  output logic [1:0]         o_state,
  output logic [COUNT_W-1:0] o_inst_count
);

  typedef enum logic [1:0] {
    StFetch  = 2'd0,
    StDecode = 2'd1,
    StMem    = 2'd2,
    StHalted = 2'd3
  } state_e;

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpLw   = 4'h1;
  localparam logic [3:0] OpSw   = 4'h2;
  localparam logic [3:0] OpPush = 4'h3;
  localparam logic [3:0] OpPop  = 4'h4;
  localparam logic [3:0] OpJ    = 4'h5;
  localparam logic [3:0] OpJal  = 4'h6;
  localparam logic [3:0] OpJr   = 4'h7;
  localparam logic [3:0] OpBeq  = 4'h8;
  localparam logic [3:0] OpHalt = 4'h9;

  state_e             r_state;
  state_e             w_state_next;
  logic [3:0]         r_opcode;
  logic [3:0]         w_opcode_next;
  logic [COUNT_W-1:0] r_count;
  logic [3:0]         w_op;
  logic               w_unused;

  assign w_op     = i_inst[15:12];
  // Operand bits belong to the datapath; only the opcode matters here.
  assign w_unused = ^i_inst[11:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StFetch;
      r_opcode <= 4'h0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_opcode <= w_opcode_next;
      if (o_retired) begin
        r_count <= r_count + COUNT_W'(1);
      end
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_opcode_next = r_opcode;
    o_pc_write    = 1'b0;
    o_sp_write    = 1'b0;
    o_mem_write   = 1'b0;
    o_inst_write  = 1'b0;
    o_mary_write  = 1'b0;
    o_ra_write    = 1'b0;
    o_pc_src      = 3'd0;
    o_sp_src      = 2'd0;
    o_mem_src     = 2'd0;
    o_mem_dst     = 3'd0;
    o_retired     = 1'b0;
    o_illegal     = 1'b0;
    o_halted      = 1'b0;
    // Outputs are gated by reset so an aborted instruction cannot complete a write.
    if (rst_n) begin
      unique case (r_state)
        StFetch: begin
          if (i_run) begin
            o_mem_src    = 2'd0;
            o_inst_write = 1'b1;
            o_pc_write   = 1'b1;
            o_pc_src     = 3'd0;
            w_state_next = StDecode;
          end
        end
        StDecode: begin
          w_opcode_next = w_op;
          w_state_next  = StFetch;
          case (w_op)
            OpNop: o_retired = 1'b1;
            OpLw: begin
              o_mem_src    = 2'd2;
              w_state_next = StMem;
            end
            OpSw: begin
              o_mem_write = 1'b1;
              o_mem_src   = 2'd2;
              o_mem_dst   = 3'd0;
              o_retired   = 1'b1;
            end
            OpPush: begin
              o_sp_write   = 1'b1;
              o_sp_src     = 2'd1;
              w_state_next = StMem;
            end
            OpPop: begin
              o_mem_src    = 2'd1;
              w_state_next = StMem;
            end
            OpJ, OpJal: begin
              o_pc_write = 1'b1;
              o_pc_src   = 3'd1;
              o_ra_write = (w_op == OpJal);
              o_retired  = 1'b1;
            end
            OpJr: begin
              o_pc_write = 1'b1;
              o_pc_src   = 3'd2;
              o_retired  = 1'b1;
            end
            OpBeq: begin
              o_pc_src   = 3'd4;
              o_pc_write = i_cmp_true;
              o_retired  = 1'b1;
            end
            OpHalt: begin
`ifdef HALT_EN
              o_retired    = 1'b1;
              w_state_next = StHalted;
`else
              o_illegal = 1'b1;
              o_retired = 1'b1;
`endif
            end
            default: begin
              o_illegal = 1'b1;
              o_retired = 1'b1;
            end
          endcase
        end
        StMem: begin
          w_state_next = StFetch;
          o_retired    = 1'b1;
          case (r_opcode)
            OpLw: begin
              o_mem_src    = 2'd2;
              o_mary_write = 1'b1;
            end
            OpPush: begin
              o_mem_write = 1'b1;
              o_mem_src   = 2'd1;
              o_mem_dst   = 3'd0;
            end
            OpPop: begin
              o_mem_src    = 2'd1;
              o_mary_write = 1'b1;
              o_sp_write   = 1'b1;
              o_sp_src     = 2'd2;
            end
            default: ;
          endcase
        end
        StHalted: begin
`ifdef HALT_EN
          o_halted     = 1'b1;
          w_state_next = StHalted;
`else
          w_state_next = StFetch;
`endif
        end
      endcase
    end
  end

  assign o_state      = r_state;
  assign o_inst_count = r_count;

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;

  typedef struct packed {
    logic       pc_write;
    logic       sp_write;
    logic       mem_write;
    logic       inst_write;
    logic       mary_write;
    logic       ra_write;
    logic [2:0] pc_src;
    logic [1:0] sp_src;
    logic [1:0] mem_src;
    logic [2:0] mem_dst;
    logic       retired;
    logic       illegal;
    logic       halted;
    logic [1:0] state;
  } out_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [15:0] inst;
  logic        cmp;

  logic        pcw_a, spw_a, memw_a, instw_a, maryw_a, raw_a, ret_a, ill_a, hlt_a;
  logic [2:0]  pcs_a, memd_a;
  logic [1:0]  sps_a, mems_a, st_a;
  logic [15:0] cnt_a;
  logic        pcw_b, spw_b, memw_b, instw_b, maryw_b, raw_b, ret_b, ill_b, hlt_b;
  logic [2:0]  pcs_b, memd_b;
  logic [1:0]  sps_b, mems_b, st_b;
  logic [3:0]  cnt_b;

  out_t obs_a, obs_b;
  assign obs_a = '{pcw_a, spw_a, memw_a, instw_a, maryw_a, raw_a, pcs_a, sps_a, mems_a, memd_a,
                   ret_a, ill_a, hlt_a, st_a};
  assign obs_b = '{pcw_b, spw_b, memw_b, instw_b, maryw_b, raw_b, pcs_b, sps_b, mems_b, memd_b,
                   ret_b, ill_b, hlt_b, st_b};

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned m_count  = 0;  // reference retired count, unbounded

  always #5 clk = ~clk;

  control_fsm #(.COUNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_run(run), .i_inst(inst), .i_cmp_true(cmp),
    .o_pc_write(pcw_a), .o_sp_write(spw_a), .o_mem_write(memw_a), .o_inst_write(instw_a),
    .o_mary_write(maryw_a), .o_ra_write(raw_a), .o_pc_src(pcs_a), .o_sp_src(sps_a),
    .o_mem_src(mems_a), .o_mem_dst(memd_a), .o_retired(ret_a), .o_illegal(ill_a),
    .o_halted(hlt_a), .o_state(st_a), .o_inst_count(cnt_a)
  );

  control_fsm #(.COUNT_W(4)) u_dut_w4 (
    .clk(clk), .rst_n(rst_n), .i_run(run), .i_inst(inst), .i_cmp_true(cmp),
    .o_pc_write(pcw_b), .o_sp_write(spw_b), .o_mem_write(memw_b), .o_inst_write(instw_b),
    .o_mary_write(maryw_b), .o_ra_write(raw_b), .o_pc_src(pcs_b), .o_sp_src(sps_b),
    .o_mem_src(mems_b), .o_mem_dst(memd_b), .o_retired(ret_b), .o_illegal(ill_b),
    .o_halted(hlt_b), .o_state(st_b), .o_inst_count(cnt_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: per-cycle expected outputs derived from the instruction semantics.
  function automatic out_t fetch_exp(input logic r);
    out_t e = '0;
    if (r) begin
      e.inst_write = 1'b1;
      e.pc_write   = 1'b1;
    end
    return e;
  endfunction

  function automatic bit is_mem_op(input logic [3:0] op);
    return (op == 4'h1) || (op == 4'h3) || (op == 4'h4);
  endfunction

  function automatic out_t decode_exp(input logic [3:0] op, input logic c);
    out_t e = '0;
    e.state   = 2'd1;
    e.retired = !is_mem_op(op);
    case (op)
      4'h0: ;
      4'h1: e.mem_src = 2'd2;
      4'h2: begin e.mem_write = 1'b1; e.mem_src = 2'd2; end
      4'h3: begin e.sp_write = 1'b1; e.sp_src = 2'd1; end
      4'h4: e.mem_src = 2'd1;
      4'h5: begin e.pc_write = 1'b1; e.pc_src = 3'd1; end
      4'h6: begin e.pc_write = 1'b1; e.pc_src = 3'd1; e.ra_write = 1'b1; end
      4'h7: begin e.pc_write = 1'b1; e.pc_src = 3'd2; end
      4'h8: begin e.pc_write = c; e.pc_src = 3'd4; end
`ifdef HALT_EN
      4'h9: ;
`endif
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  function automatic out_t mem_exp(input logic [3:0] op);
    out_t e = '0;
    e.state   = 2'd2;
    e.retired = 1'b1;
    case (op)
      4'h1: begin e.mem_src = 2'd2; e.mary_write = 1'b1; end
      4'h3: begin e.mem_write = 1'b1; e.mem_src = 2'd1; end
      4'h4: begin e.mem_src = 2'd1; e.mary_write = 1'b1; e.sp_write = 1'b1; e.sp_src = 2'd2; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic check_counts(input string tag);
    check_eq({tag, "_cnt16"}, 32'(cnt_a), m_count & 32'hffff);
    check_eq({tag, "_cnt4"}, 32'(cnt_b), m_count & 32'hf);
  endtask

  // Inputs are already set; sample mid-cycle, then advance past the next rising edge.
  task automatic do_cycle(input string tag, input out_t e);
    #2;
    check_eq({tag, "_a"}, 32'(obs_a), 32'(e));
    check_eq({tag, "_b"}, 32'(obs_b), 32'(e));
    check_counts(tag);
    if (e.retired) m_count++;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    m_count = 0;
    #1;
    check_eq({tag, "_out"}, 32'(obs_a), 32'h0);
    check_counts(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic exec(input logic [3:0] op, input logic c, input bit allow_stall,
                      input bit abort_mem);
    out_t e;
    inst = {op, 12'($urandom)};
    cmp  = 1'($urandom);
    if (allow_stall && $urandom_range(0, 3) == 0) begin
      run = 1'b0;
      do_cycle("idle", fetch_exp(1'b0));
    end
    run = 1'b1;
    do_cycle("fetch", fetch_exp(1'b1));
    run = 1'($urandom);
    cmp = c;
    do_cycle("decode", decode_exp(op, c));
    if (is_mem_op(op)) begin
      // Opcode must come from the DECODE latch, not the live instruction.
      inst = 16'($urandom);
      run  = 1'($urandom);
      if (abort_mem) begin
        rst_n = 1'b0;
        #1;
        check_eq("abort_out", 32'(obs_a), 32'h0);
        check_eq("abort_mary", 32'(maryw_a), 32'h0);
        check_eq("abort_cnt", 32'(cnt_a), m_count & 32'hffff);
        m_count = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end else begin
        do_cycle("mem", mem_exp(op));
      end
    end
`ifdef HALT_EN
    if (op == 4'h9) begin
      e = '0;
      e.halted = 1'b1;
      e.state  = 2'd3;
      run = 1'b1;
      for (int i = 0; i < 3; i++) do_cycle("halted", e);
      apply_reset("halt_rst");
    end
`else
    e = '0;
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    run   = 1'b1;
    inst  = 16'h0000;
    cmp   = 1'b0;
    apply_reset("reset");

    // NOP, then PUSH/POP, BEQ both ways, HALT
    exec(4'h0, 1'b0, 1'b0, 1'b0);
    check_eq("nop_count", 32'(cnt_a), 32'd1);
    exec(4'h3, 1'b0, 1'b0, 1'b0);
    exec(4'h4, 1'b0, 1'b0, 1'b0);
    check_eq("pushpop_count", 32'(cnt_a), 32'd3);
    exec(4'h8, 1'b1, 1'b0, 1'b0);
    exec(4'h8, 1'b0, 1'b0, 1'b0);
    exec(4'h9, 1'b0, 1'b0, 1'b0);

    // Reset during the MEM cycle of LW
    apply_reset("pre_abort");
    exec(4'h1, 1'b0, 1'b0, 1'b1);
    run = 1'b0;
    do_cycle("post_abort", fetch_exp(1'b0));

    // 16 NOPs exercise the narrow counter wrap
    apply_reset("pre_wrap");
    for (int i = 0; i < 15; i++) exec(4'h0, 1'b0, 1'b0, 1'b0);
    check_eq("wrap4_15", 32'(cnt_b), 32'd15);
    exec(4'h0, 1'b0, 1'b0, 1'b0);
    check_eq("wrap4_0", 32'(cnt_b), 32'd0);
    check_eq("wrap16_16", 32'(cnt_a), 32'd16);

    // Randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      exec(4'($urandom_range(0, 15)), 1'($urandom), 1'b1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
